// File: rtl/axi_xbar_id_tracker.sv
// axi_xbar_id_tracker
// Per-ID outstanding-transaction tracker for one crossbar demux port.
// Each table entry (indexed by the low LOOKUP_BITS of the ID) holds an
// in-flight count and the slave select that the ID is currently routed to.
// The demux queries the table combinationally and stalls any same-ID request
// that would target a different slave. This keeps AXI same-ID responses in order.
// IDs that alias on the index bits share an entry. That is conservative, but safe.
module axi_xbar_id_tracker #(
  parameter  int unsigned ID_WIDTH    = 6,
  parameter  int unsigned LOOKUP_BITS = 4,
  parameter  int unsigned MAX_TRANS   = 8,
  parameter  int unsigned NUM_SLV     = 4,
  localparam int unsigned SEL_WIDTH   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
  localparam int unsigned CNT_WIDTH   = $clog2(MAX_TRANS + 1),
  localparam int unsigned TOT_WIDTH   = $clog2((2 ** LOOKUP_BITS) * MAX_TRANS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // query port
  input  logic [ID_WIDTH-1:0]  lookup_id_i,
  output logic [SEL_WIDTH-1:0] lookup_sel_o,
  output logic                 lookup_occupied_o,
  output logic                 lookup_full_o,
  // accepted transaction
  input  logic                 push_i,
  input  logic [ID_WIDTH-1:0]  push_id_i,
  input  logic [SEL_WIDTH-1:0] push_sel_i,
  // completed transaction
  input  logic                 pop_i,
  input  logic [ID_WIDTH-1:0]  pop_id_i,
  // aggregate status and sticky errors
  output logic                 any_outstanding_o,
  output logic [TOT_WIDTH-1:0] tot_cnt_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic                 mismatch_o
);

  localparam int unsigned ENTRIES = 2 ** LOOKUP_BITS;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_TRANS);
  localparam logic [TOT_WIDTH-1:0] TOT_ZERO = {TOT_WIDTH{1'b0}};
  localparam logic [TOT_WIDTH-1:0] TOT_ONE  = TOT_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_ZERO = {SEL_WIDTH{1'b0}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_q [ENTRIES];
  logic [CNT_WIDTH-1:0] cnt_d [ENTRIES];
  logic [SEL_WIDTH-1:0] sel_q [ENTRIES];
  logic [SEL_WIDTH-1:0] sel_d [ENTRIES];
  logic [TOT_WIDTH-1:0] tot_q;
  logic [TOT_WIDTH-1:0] tot_d;
  logic                 overflow_q;
  logic                 overflow_d;
  logic                 underflow_q;
  logic                 underflow_d;
  logic                 mismatch_q;
  logic                 mismatch_d;

  // ---------------------------------------------------------------------------
  // Index extraction and select normalisation
  // ---------------------------------------------------------------------------
  logic [LOOKUP_BITS-1:0] lookup_idx_s;
  logic [LOOKUP_BITS-1:0] push_idx_s;
  logic [LOOKUP_BITS-1:0] pop_idx_s;
  logic [SEL_WIDTH-1:0]   push_sel_s;

  assign lookup_idx_s = lookup_id_i[LOOKUP_BITS-1:0];
  assign push_idx_s   = push_id_i[LOOKUP_BITS-1:0];
  assign pop_idx_s    = pop_id_i[LOOKUP_BITS-1:0];

  // The upper ID bits only matter to the demux. Aliasing IDs share an entry.
  if (ID_WIDTH > LOOKUP_BITS) begin : g_unused_id
    logic unused_id_bits_s;
    assign unused_id_bits_s = ^{lookup_id_i[ID_WIDTH-1:LOOKUP_BITS],
                                push_id_i[ID_WIDTH-1:LOOKUP_BITS],
                                pop_id_i[ID_WIDTH-1:LOOKUP_BITS]};
  end

  // A single-slave build has nowhere else to route, so its select is pinned to 0.
  if (NUM_SLV > 1) begin : g_multi_slv
    assign push_sel_s = push_sel_i;
  end else begin : g_single_slv
    logic unused_push_sel_s;
    assign unused_push_sel_s = ^push_sel_i;
    assign push_sel_s        = SEL_ZERO;
  end

  // ---------------------------------------------------------------------------
  // Push / pop qualification against the pre-edge state
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] push_cnt_s;
  logic [SEL_WIDTH-1:0] push_cur_sel_s;
  logic [CNT_WIDTH-1:0] pop_cnt_s;
  logic                 push_full_s;
  logic                 push_conflict_s;
  logic                 pop_empty_s;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  assign push_cnt_s     = cnt_q[push_idx_s];
  assign push_cur_sel_s = sel_q[push_idx_s];
  assign pop_cnt_s      = cnt_q[pop_idx_s];

  // Judge each request on the registered count. A same-entry pop therefore
  // neither frees room for, nor blocks, a push in the same cycle.
  always_comb begin
    push_full_s     = (push_cnt_s == CNT_MAX);
    push_conflict_s = (push_cnt_s != CNT_ZERO) && (push_cur_sel_s != push_sel_s);
    pop_empty_s     = (pop_cnt_s == CNT_ZERO);
    push_ok_s       = push_i && !push_full_s && !push_conflict_s;
    pop_ok_s        = pop_i && !pop_empty_s;
  end

  // ---------------------------------------------------------------------------
  // Entry update
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0] push_hit_s;
  logic [ENTRIES-1:0] pop_hit_s;

  // Decode the accepted push and pop into one-hot entry strobes.
  always_comb begin
    push_hit_s             = {ENTRIES{1'b0}};
    pop_hit_s              = {ENTRIES{1'b0}};
    push_hit_s[push_idx_s] = push_ok_s;
    pop_hit_s[pop_idx_s]   = pop_ok_s;
  end

  // Next count and select per entry. A push and a pop on the same entry cancel
  // out. The select is kept when an entry drains, so it only moves on a push.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      cnt_d[i] = cnt_q[i];
      sel_d[i] = sel_q[i];
      case ({push_hit_s[i], pop_hit_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
      if (push_hit_s[i]) begin
        sel_d[i] = push_sel_s;
      end else begin
        sel_d[i] = sel_q[i];
      end
    end
  end

  // Aggregate count follows the net of the accepted operations.
  always_comb begin
    tot_d = tot_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   tot_d = tot_q + TOT_ONE;
      2'b01:   tot_d = tot_q - TOT_ONE;
      default: tot_d = tot_q;
    endcase
  end

  // Sticky error flags. Full and mismatch can fire together on one push.
  always_comb begin
    overflow_d  = overflow_q  || (push_i && push_full_s);
    mismatch_d  = mismatch_q  || (push_i && push_conflict_s);
    underflow_d = underflow_q || (pop_i && pop_empty_s);
  end

  // State register. Reset wins over any push or pop in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_ZERO;
        sel_q[i] <= SEL_ZERO;
      end
      tot_q       <= TOT_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= cnt_d[i];
        sel_q[i] <= sel_d[i];
      end
      tot_q       <= tot_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      mismatch_q  <= mismatch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Zero-latency lookup so the demux can stall in the cycle the request arrives.
  always_comb begin
    lookup_sel_o      = sel_q[lookup_idx_s];
    lookup_occupied_o = (cnt_q[lookup_idx_s] != CNT_ZERO);
    lookup_full_o     = (cnt_q[lookup_idx_s] == CNT_MAX);
  end

  assign tot_cnt_o         = tot_q;
  assign any_outstanding_o = (tot_q != TOT_ZERO);
  assign overflow_o        = overflow_q;
  assign underflow_o       = underflow_q;
  assign mismatch_o        = mismatch_q;

endmodule

// File: doc/axi_xbar_id_tracker.md
Name: axi_xbar_id_tracker

Overview:
Per-ID outstanding-transaction tracker for one crossbar demux port. It is instantiated once per master-side AW/AR channel. It counts in-flight transactions per ID and records which slave port each active ID is routed to. The demux uses this to stall any same-ID request that would target a different slave, which preserves AXI same-ID ordering. Table size, depth and slave count are generalised; the block adds overflow, underflow and mismatch error detection plus an aggregate outstanding count.

Parameters:
ID_WIDTH, 6, width of the slave-side AXI ID.
LOOKUP_BITS, 4, number of low ID bits used to index the table (1..ID_WIDTH); the table has 2**LOOKUP_BITS entries.
MAX_TRANS, 8, maximum outstanding transactions per entry (>=1).
NUM_SLV, 4, number of slave ports (>=1).
SEL_WIDTH, max(1, clog2(NUM_SLV)), derived, width of the slave select.
CNT_WIDTH, clog2(MAX_TRANS+1), derived, width of the per-entry counter.
TOT_WIDTH, clog2((2**LOOKUP_BITS)*MAX_TRANS+1), derived, width of the aggregate counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
lookup_id_i  in  ID_WIDTH  ID being queried; only the low LOOKUP_BITS are used.
lookup_sel_o  out  SEL_WIDTH  slave select stored for the queried entry.
lookup_occupied_o  out  1  queried entry count is non-zero.
lookup_full_o  out  1  queried entry count equals MAX_TRANS.
push_i  in  1  a transaction was accepted downstream; one push per cycle.
push_id_i  in  ID_WIDTH  ID of the pushed transaction.
push_sel_i  in  SEL_WIDTH  slave select of the pushed transaction.
pop_i  in  1  a transaction completed (last response handshake); one pop per cycle.
pop_id_i  in  ID_WIDTH  ID of the completed transaction.
any_outstanding_o  out  1  tot_cnt_o is non-zero.
tot_cnt_o  out  TOT_WIDTH  total outstanding transactions across all entries.
overflow_o  out  1  sticky: a push was attempted on a full entry.
underflow_o  out  1  sticky: a pop was attempted on an empty entry.
mismatch_o  out  1  sticky: a push was attempted on an occupied entry with a different select.

Behaviour:
- State: per entry, cnt[CNT_WIDTH] and sel[SEL_WIDTH]; a tot counter; three sticky flags. All state is registered.
- Reset: when rst_i is high at a rising edge, every cnt, sel, tot and flag goes to 0. push_i and pop_i are ignored in that cycle. After reset: lookup_sel_o=0, lookup_occupied_o=0, lookup_full_o=0, any_outstanding_o=0, tot_cnt_o=0, all error flags 0.
- Lookup outputs are combinational from lookup_id_i and the current state (zero latency). Updates from push/pop become visible on the cycle after the edge.
- Push is valid when push_i=1 and all of the following hold:
  - cnt<MAX_TRANS;
  - cnt==0 or sel==push_sel_i.
  On a valid push: cnt+1, sel<=push_sel_i, tot+1.
- Invalid push: the entry is unchanged and tot is unchanged. A full entry sets overflow_o. A select mismatch sets mismatch_o. If both conditions hold, both flags are set.
- Pop is valid when pop_i=1 and cnt>0; it does cnt-1 and tot-1. sel is retained when cnt reaches 0; it is don't-care while unoccupied but must not change. Pop at cnt==0 is ignored and sets underflow_o.
- Simultaneous push and pop, different entries: each is evaluated independently against the pre-edge state. tot changes by the net of the two valid operations.
- Simultaneous push and pop, same entry: validity of each is judged on the pre-edge cnt.
  - Full entry with push+pop: the pop is valid and the push is invalid (overflow_o set), so the net result is cnt-1.
  - Empty entry with push+pop: the pop is invalid (underflow_o set) and the push is valid, so the net result is cnt+1 and sel is loaded.
  - Otherwise both are valid: cnt and tot are unchanged, and sel<=push_sel_i (allowed only when the selects match or cnt==0).
- IDs that alias on the low LOOKUP_BITS share one entry. This is intentional: it is conservative ordering.
- Sticky flags clear only on reset.
- A NUM_SLV==1 build uses a 1-bit select that is always 0.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, then release -> all outputs 0; lookup of id 0x3F gives occupied=0 and full=0.
- Fill and drain: 8 pushes id=0x05 sel=2, then lookup id=0x05 -> cnt full, lookup_full_o=1, lookup_sel_o=2, tot_cnt_o=8. A 9th push -> overflow_o=1 and tot_cnt_o stays 8. Then 8 pops -> occupied=0 and tot=0. One more pop -> underflow_o=1.
- Mismatch stall: push id=0x11 sel=1, then push id=0x01 sel=3 (aliases with LOOKUP_BITS=4) -> mismatch_o=1; the entry keeps sel=1 and cnt=1.
- Simultaneous same-entry push+pop: with id=0x07 at cnt=3 sel=0, push+pop id=0x07 -> cnt stays 3 and tot is unchanged. With id=0x08 empty, push(sel=2)+pop -> cnt=1, sel=2, underflow_o=1.
- Mid-operation reset: 5 entries occupied and tot=12; assert rst_i for 1 cycle with push_i=1 -> everything is 0 on the next cycle and the push is lost.
- Parameter sweep: LOOKUP_BITS=1, MAX_TRANS=1, NUM_SLV=1 -> single push sets full; a second push sets overflow_o; SEL_WIDTH=1 and lookup_sel_o=0.
